// File: rtl/regdst_tracker_if.sv
// Bus between the decode stage and regdst_tracker: destination select inputs,
// issue/commit handshakes, writeback head and hazard flags.
interface regdst_tracker_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [2:0]        RegDst;
  logic [ADDR_W-1:0] in_rt;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs;
  logic [ADDR_W-1:0] sel_dst;
  logic              issue_valid;
  logic              issue_ready;
  logic              commit_valid;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dst;
  logic              hazard_rs;
  logic              hazard_rt;
  logic [CNT_W-1:0]  pend_count;

  modport master (
    output RegDst, in_rt, in_rd, in_rs, issue_valid, commit_valid,
    input  sel_dst, issue_ready, wb_valid, wb_dst, hazard_rs, hazard_rt, pend_count
  );

  modport slave (
    input  RegDst, in_rt, in_rd, in_rs, issue_valid, commit_valid,
    output sel_dst, issue_ready, wb_valid, wb_dst, hazard_rs, hazard_rt, pend_count
  );
endinterface

// File: rtl/regdst_tracker.sv
// Destination-register select, in-order pending-write FIFO and per-register hazard counters.
// Optional macro REGDST_COMMIT_BYPASS_EN: hide a hazard whose only pending write commits this cycle.
module regdst_tracker #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int REG_RA = 31,
  parameter int REG_SP = 29
) (
  input logic             clk,
  input logic             reset,
  regdst_tracker_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] RA_IDX = ADDR_W'(REG_RA);
  localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(REG_SP);

  logic [ADDR_W-1:0] fifo [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cnt [NREGS];

  logic [ADDR_W-1:0] sel_dst;
  logic [ADDR_W-1:0] wb_dst;
  logic              issue_ready;
  logic              wb_valid;
  logic              push;
  logic              pop;
  logic [NREGS-1:0]  inc;
  logic [NREGS-1:0]  dec;
  logic [CNT_W-1:0]  cnt_rs;
  logic [CNT_W-1:0]  cnt_rt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_dst = '0;
    case (bus.RegDst)
      3'b000:  sel_dst = bus.in_rt;
      3'b001:  sel_dst = bus.in_rd;
      3'b010:  sel_dst = RA_IDX;
      3'b011:  sel_dst = SP_IDX;
      3'b100:  sel_dst = bus.in_rs;
      default: sel_dst = '0;
    endcase
  end

  assign issue_ready = (count != FULL_CNT);
  assign wb_valid    = (count != '0);
  assign wb_dst      = fifo[head];
  assign push        = bus.issue_valid && issue_ready;
  assign pop         = bus.commit_valid && wb_valid;

  // Register 0 is a FIFO citizen but never tracked as a hazard source.
  always_comb begin
    inc = '0;
    dec = '0;
    if (push && (sel_dst != '0)) inc[sel_dst] = 1'b1;
    if (pop && (wb_dst != '0))   dec[wb_dst]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[tail] <= sel_dst;
        tail       <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREGS; r++) begin
        if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  assign cnt_rs = cnt[bus.in_rs];
  assign cnt_rt = cnt[bus.in_rt];

`ifdef REGDST_COMMIT_BYPASS_EN
  // The writeback path forwards the committing value, so a lone pending write is already resolved.
  logic byp_rs;
  logic byp_rt;
  assign byp_rs        = pop && (wb_dst == bus.in_rs) && (cnt_rs == CNT_W'(1));
  assign byp_rt        = pop && (wb_dst == bus.in_rt) && (cnt_rt == CNT_W'(1));
  assign bus.hazard_rs = (cnt_rs != '0) && !byp_rs;
  assign bus.hazard_rt = (cnt_rt != '0) && !byp_rt;
`else
  assign bus.hazard_rs = (cnt_rs != '0);
  assign bus.hazard_rt = (cnt_rt != '0);
`endif

  assign bus.sel_dst     = sel_dst;
  assign bus.issue_ready = issue_ready;
  assign bus.wb_valid    = wb_valid;
  assign bus.wb_dst      = wb_dst;
  assign bus.pend_count  = count;
endmodule

// File: doc/regdst_tracker.md
Name: regdst_tracker

Overview:
- Parametrised successor to the datapath's combinational destination-register mux.
- Selects the write-destination register from rt/rd/rs/RA/SP using the same 3-bit RegDst code.
- Queues the selected destinations for multi-cycle writers (mult/div/load) in a DEPTH-entry in-order FIFO, committed at writeback.
- Keeps a per-register pending counter so the control FSM can detect read-after-write hazards on rs/rt before issuing.
- Sits between the decode stage and the register-file write port.

Parameters:
- ADDR_W, 5, register address width; the register file has 2**ADDR_W entries.
- DEPTH, 4, maximum outstanding pending writes (>=1, power of two).
- REG_RA, 31, register index used for RegDst=010 (return address).
- REG_SP, 29, register index used for RegDst=011 (stack pointer).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- RegDst  in  3  destination select code.
- in_rt  in  ADDR_W  instruction rt field.
- in_rd  in  ADDR_W  instruction rd field.
- in_rs  in  ADDR_W  instruction rs field.
- sel_dst  out  ADDR_W  combinational selected destination.
- issue_valid  in  1  request to enqueue sel_dst as a pending write.
- issue_ready  out  1  queue can accept (count < DEPTH).
- commit_valid  in  1  writeback of the head entry occurs this cycle.
- wb_valid  out  1  queue non-empty; wb_dst is meaningful.
- wb_dst  out  ADDR_W  destination of the oldest pending write (head).
- hazard_rs  out  1  in_rs has a pending write.
- hazard_rt  out  1  in_rt has a pending write.
- pend_count  out  clog2(DEPTH+1)  number of queued entries.

Behaviour:
- Select decode (combinational):
  - 000 → in_rt; 001 → in_rd; 010 → REG_RA; 011 → REG_SP; 100 → in_rs.
  - 101, 110, 111 → 0.
- Issue handshake:
  - An entry is accepted on a rising edge with reset=1, issue_valid=1 and issue_ready=1.
  - sel_dst is written at the tail; the tail pointer increments modulo DEPTH.
  - issue_valid with issue_ready=0 is dropped with no state change. The requester must hold the request.
- Commit:
  - On an edge with commit_valid=1 and wb_valid=1, the head pops and the head pointer increments modulo DEPTH.
  - commit_valid while empty is ignored: pointers, counts and pending counters are unchanged.
- Pending counters:
  - One counter per register, width clog2(DEPTH+1).
  - Accepted issue increments cnt[sel_dst]; valid commit decrements cnt[wb_dst].
  - Issue and commit to the same register in the same cycle leave that counter unchanged.
  - Register 0 is never counted: issue/commit with dst 0 still occupy a FIFO slot, but cnt[0] stays 0.
- Hazards (combinational):
  - hazard_rs = (cnt[in_rs] != 0); hazard_rt = (cnt[in_rt] != 0).
  - Both are 0 whenever the field is 0.
- Simultaneous issue and commit:
  - When full, issue_ready=0, so the issue is not accepted even with commit in the same cycle. Commit proceeds and the next cycle has room.
  - When neither full nor empty, both are performed and pend_count is unchanged.
- Occupancy flags:
  - issue_ready = (pend_count != DEPTH); wb_valid = (pend_count != 0).
  - wb_dst = fifo[head], undefined-safe: it shows the stale slot when empty and is gated only by wb_valid.
- Latency: an issued entry is visible on wb_dst/hazard_* the cycle after acceptance.
- Reset (reset=0 at an edge):
  - Pointers, pend_count and all pending counters are cleared; FIFO storage is cleared to 0.
  - Next cycle: wb_valid=0, issue_ready=1, wb_dst=0, hazard_rs=hazard_rt=0.
  - Reset overrides any simultaneous issue/commit; entries pending at reset are discarded.

Optional Feature:
- Macro: REGDST_COMMIT_BYPASS_EN.
- Defined: hazard_rs/rt are suppressed when the only pending write to that register is committing this cycle, i.e. commit_valid=1, wb_valid=1, wb_dst equals the field, and cnt==1. This allows same-cycle forwarding from the writeback path.
- Undefined: hazard_* depend only on registered counters; the committing register still reports a hazard that cycle.

Test Plan:
- Reset held low 2 cycles, then RegDst sweep 000..111 with rt=8, rd=9, rs=10 → sel_dst = 8, 9, 31, 29, 10, 0, 0, 0; wb_valid=0, issue_ready=1, pend_count=0.
- Issue dsts 8, 9, 31, 29 on consecutive cycles → after the 4th, issue_ready=0, pend_count=4. A 5th issue (dst 10) is dropped. Commits return wb_dst 8, 9, 31, 29 in order, then wb_valid=0.
- Issue dst 8 twice, in_rs=8 → hazard_rs=1. After one commit, hazard_rs=1 (cnt=1). After the second commit, hazard_rs=0.
- Full queue, issue_valid=1 and commit_valid=1 in the same cycle → one pop, no push, pend_count 4→3. Non-full, same stimulus → pend_count unchanged, tail and head both advance.
- Issue with RegDst=101 (dst 0), in_rt=0 → pend_count=1, hazard_rt=0; commit pops it with wb_dst=0. Commit on empty → no change, pend_count stays 0.
- Issue 2 entries, assert reset=0 together with issue_valid → next cycle pend_count=0, wb_valid=0, all hazards 0. With REGDST_COMMIT_BYPASS_EN: one pending write to 12, in_rt=12, commit_valid=1 → hazard_rt=0 that cycle (=1 without the macro).
